// File: rtl/tas_pkg.sv
// tas_pkg: shared state type, packet constants and header check for tas_pkt_serializer.
package tas_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DROP} ser_state_t;
    localparam logic [2:0] TAS_PKT_BYTES = 3'd5;
    localparam logic [7:0] TAS_HDR_A = 8'hA5;
    localparam logic [7:0] TAS_HDR_B = 8'hC3;
    function automatic logic is_valid_hdr(input logic [7:0] b);
        return b == TAS_HDR_A || b == TAS_HDR_B;
    endfunction
endpackage

// File: rtl/tas_pkt_serializer.sv
// tas_pkt_serializer: 5-byte packets in, LSB-first serial bytes out with an idle gap after each.
// Define TAS_SER_HDR_CHECK_EN to drop packets whose header is neither A5 nor C3.
module tas_pkt_serializer
    import tas_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_sop,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       serial_data,
    output logic       data_ena,
    output logic       busy,
    output logic       pkt_sent,
    output logic       frame_err,
    output logic       hdr_drop
);
    if (GAP_CYCLES < 2 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be in 2..15");
    end
    ser_state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       last_q, last_d;
    logic       in_ready_q, in_ready_d, serial_q, serial_d, data_ena_q, data_ena_d, busy_q, busy_d;
    logic       pkt_sent_q, pkt_sent_d, frame_err_q, frame_err_d, hdr_drop_q, hdr_drop_d;
    logic       hs, hdr_ok, last_idx, gap_done;
    assign hs       = in_valid & in_ready_q;
    assign last_idx = byte_idx_q == TAS_PKT_BYTES - 3'd1;
    assign gap_done = gap_cnt_q == 4'(GAP_CYCLES - 1);
`ifdef TAS_SER_HDR_CHECK_EN
    assign hdr_ok = is_valid_hdr(in_data);
`else
    assign hdr_ok = 1'b1;
`endif
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            gap_cnt_q   <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            serial_q    <= 1'b0;
            data_ena_q  <= 1'b0;
            busy_q      <= 1'b0;
            pkt_sent_q  <= 1'b0;
            frame_err_q <= 1'b0;
            hdr_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            serial_q    <= serial_d;
            data_ena_q  <= data_ena_d;
            busy_q      <= busy_d;
            pkt_sent_q  <= pkt_sent_d;
            frame_err_q <= frame_err_d;
            hdr_drop_q  <= hdr_drop_d;
        end
    end
    // last_q marks the byte in flight as the 5th of an in-order packet, so pkt_sent fires at its gap end
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        pkt_sent_d  = 1'b0;
        frame_err_d = 1'b0;
        hdr_drop_d  = 1'b0;
        case (state_q)
            SHIFT: begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = bit_cnt_q == 3'd7 ? GAP : SHIFT;
                gap_cnt_d = '0;
            end
            GAP: begin
                gap_cnt_d  = gap_cnt_q + 4'd1;
                state_d    = gap_done ? IDLE : GAP;
                pkt_sent_d = gap_done & last_q;
                last_d     = last_q & ~gap_done;
            end
            default: if (hs) begin
                if (in_sop) begin
                    frame_err_d = byte_idx_q != '0;
                    byte_idx_d  = 3'd1;
                    last_d      = 1'b0;
                    shreg_d     = in_data;
                    bit_cnt_d   = '0;
                    state_d     = hdr_ok ? SHIFT : DROP;
                end else if (byte_idx_q == '0) begin
                    frame_err_d = 1'b1;
                end else if (state_q == DROP) begin
                    byte_idx_d = last_idx ? '0 : byte_idx_q + 3'd1;
                    hdr_drop_d = last_idx;
                    state_d    = last_idx ? IDLE : DROP;
                end else begin
                    byte_idx_d = last_idx ? '0 : byte_idx_q + 3'd1;
                    last_d     = last_idx;
                    shreg_d    = in_data;
                    bit_cnt_d  = '0;
                    state_d    = SHIFT;
                end
            end
        endcase
    end
    always_comb begin
        in_ready_d = state_d == IDLE || state_d == DROP;
        data_ena_d = state_d == SHIFT;
        serial_d   = data_ena_d & shreg_d[0];
        busy_d     = state_d != IDLE;
    end
    assign in_ready    = in_ready_q;
    assign serial_data = serial_q;
    assign data_ena    = data_ena_q;
    assign busy        = busy_q;
    assign pkt_sent    = pkt_sent_q;
    assign frame_err   = frame_err_q;
    assign hdr_drop    = hdr_drop_q;
endmodule
